clk_divider_bank: RTL and testbench

Parametrised bank of NCH independent programmable clock dividers running from the single 50 MHz system clock. Each channel produces a one-cycle enable pulse (`tick_o`) and a square-wave divided clock (`div_clk_o`) from a runtime-programmable divisor. The bank supersedes the fixed 32-bit counter divider and is the common source for slow enables (display scan, debounce, UART baud, CPU single-step) across the MIPS design.

---
 rtl/clk_divider_bank.sv | 114 +++++++++++
 tb/tb_clk_divider_bank.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/clk_divider_bank.sv
// Bank of NCH independent programmable clock dividers. Each channel emits a
// registered one-cycle tick and a registered square-wave divided clock.
module clk_divider_bank #(
  parameter int NCH         = 4,
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 50_000_000,
  localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [CHW-1:0]   cfg_ch_i,
  input  logic [WIDTH-1:0] cfg_div_i,
  output logic [NCH-1:0]   tick_o,
  output logic [NCH-1:0]   div_clk_o,
  output logic [NCH-1:0]   pend_o
);

  localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
  localparam logic             RST_TICK = (DEFAULT_DIV == 1);
  localparam logic             RST_DCLK = (DEFAULT_DIV >= 2);

  logic [WIDTH-1:0] cnt_q   [NCH];
  logic [WIDTH-1:0] div_q   [NCH];
  logic [WIDTH-1:0] dpend_q [NCH];
  logic [WIDTH-1:0] cnt_d   [NCH];
  logic [WIDTH-1:0] div_d   [NCH];
  logic [WIDTH-1:0] dpend_d [NCH];
  logic [NCH-1:0]   pend_q, pend_d;
  logic [NCH-1:0]   tick_q, tick_d;
  logic [NCH-1:0]   dclk_q, dclk_d;
  logic [NCH-1:0]   run, wrap, wr;
  logic [(2**CHW)-1:0] pend_ext;
  logic             accept;

  // Padding the pend vector makes out-of-range channels read as ready.
  always_comb begin
    pend_ext          = '0;
    pend_ext[NCH-1:0] = pend_q;
  end

  assign cfg_ready_o = !pend_ext[cfg_ch_i];
  assign accept      = cfg_valid_i && cfg_ready_o;

  always_comb begin
    run     = '0;
    wrap    = '0;
    wr      = '0;
    pend_d  = pend_q;
    tick_d  = '0;
    dclk_d  = '0;
    cnt_d   = cnt_q;
    div_d   = div_q;
    dpend_d = dpend_q;
    for (int i = 0; i < NCH; i++) begin
      run[i]  = (div_q[i] != '0);
      wrap[i] = run[i] && (cnt_q[i] == div_q[i] - WIDTH'(1));
      wr[i]   = accept && (cfg_ch_i == CHW'(i));

      cnt_d[i] = (run[i] && !wrap[i]) ? cnt_q[i] + WIDTH'(1) : '0;

      // A pending divisor lands at the period boundary or on a sync strobe.
      if (pend_q[i] && (wrap[i] || sync_i)) begin
        div_d[i]  = dpend_q[i];
        pend_d[i] = 1'b0;
      end
      if (sync_i)
        cnt_d[i] = '0;

      // An accepted write implies pend_q[i] is clear, so no conflict above.
      if (wr[i]) begin
        if (!run[i] || sync_i) begin
          div_d[i] = cfg_div_i;
          cnt_d[i] = '0;
        end else begin
          dpend_d[i] = cfg_div_i;
          pend_d[i]  = 1'b1;
        end
      end

      tick_d[i] = (div_d[i] != '0) && (cnt_d[i] == div_d[i] - WIDTH'(1));
      dclk_d[i] = (cnt_d[i] < (div_d[i] >> 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]   <= '0;
        div_q[i]   <= RST_DIV;
        dpend_q[i] <= '0;
      end
      pend_q <= '0;
      tick_q <= {NCH{RST_TICK}};
      dclk_q <= {NCH{RST_DCLK}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        div_q[i]   <= div_d[i];
        dpend_q[i] <= dpend_d[i];
      end
      pend_q <= pend_d;
      tick_q <= tick_d;
      dclk_q <= dclk_d;
    end
  end

  assign tick_o    = tick_q;
  assign div_clk_o = dclk_q;
  assign pend_o    = pend_q;

endmodule

// File: tb/tb_clk_divider_bank.sv
// Directed bench for clk_divider_bank: a per-cycle vector table plus reset
// sequences; a second NCH=5 instance exercises an out-of-range channel write.
module tb_clk_divider_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sync_i;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [3:0] tick, dclk, pend;

  logic       valid5;
  logic       ready5;
  logic [2:0] ch5;
  logic [4:0] tick5, dclk5, pend5;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clk_divider_bank #(.NCH(4), .WIDTH(8), .DEFAULT_DIV(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .sync_i(sync_i),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_ch_i(cfg_ch), .cfg_div_i(cfg_div),
    .tick_o(tick), .div_clk_o(dclk), .pend_o(pend)
  );

  clk_divider_bank #(.NCH(5), .WIDTH(8), .DEFAULT_DIV(4)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .sync_i(sync_i),
    .cfg_valid_i(valid5), .cfg_ready_o(ready5),
    .cfg_ch_i(ch5), .cfg_div_i(cfg_div),
    .tick_o(tick5), .div_clk_o(dclk5), .pend_o(pend5)
  );

  typedef struct {
    logic       sync;
    logic       valid;
    logic [1:0] ch;
    logic [7:0] div;
    logic [3:0] tick;
    logic [3:0] dclk;
    logic [3:0] pend;
    logic       ready;
  } vec_t;

  vec_t vt [23];

  task automatic setv(input int k, input logic s, input logic v,
                      input logic [1:0] c, input logic [7:0] d,
                      input logic [3:0] t, input logic [3:0] dc,
                      input logic [3:0] p, input logic r);
    vt[k].sync  = s;
    vt[k].valid = v;
    vt[k].ch    = c;
    vt[k].div   = d;
    vt[k].tick  = t;
    vt[k].dclk  = dc;
    vt[k].pend  = p;
    vt[k].ready = r;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Default-divisor pattern for the 5-channel instance at counter phase ph.
  task automatic chk5(input string tag, input int ph);
    chk({tag, " tick5"}, {3'b0, tick5}, (ph == 3) ? 8'h1F : 8'h00);
    chk({tag, " dclk5"}, {3'b0, dclk5}, (ph < 2) ? 8'h1F : 8'h00);
    chk({tag, " pend5"}, {3'b0, pend5}, 8'h00);
    chk({tag, " ready5"}, {7'b0, ready5}, 8'h01);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " tick"}, {4'b0, tick}, 8'h00);
    chk({tag, " dclk"}, {4'b0, dclk}, 8'h0F);
    chk({tag, " pend"}, {4'b0, pend}, 8'h00);
    chk({tag, " ready"}, {7'b0, cfg_ready}, 8'h01);
    chk({tag, " dclk5"}, {3'b0, dclk5}, 8'h1F);
  endtask

  initial begin
    //   k  sync  valid ch     div     tick   dclk   pend   ready
    setv( 0, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'hF, 4'h0, 1'b1);
    setv( 1, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'hF, 4'h0, 1'b1);
    setv( 2, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0, 1'b1);
    setv( 3, 1'b0, 1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 4'h0, 1'b1);
    setv( 4, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'hF, 4'h0, 1'b1);
    setv( 5, 1'b0, 1'b1, 2'd1, 8'd3, 4'h0, 4'hF, 4'h0, 1'b1);
    setv( 6, 1'b0, 1'b0, 2'd1, 8'd0, 4'h0, 4'h0, 4'h2, 1'b0);
    setv( 7, 1'b0, 1'b0, 2'd1, 8'd0, 4'hF, 4'h0, 4'h2, 1'b0);
    setv( 8, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'hF, 4'h0, 1'b1);
    setv( 9, 1'b0, 1'b1, 2'd2, 8'd0, 4'h0, 4'hD, 4'h0, 1'b1);
    setv(10, 1'b0, 1'b0, 2'd2, 8'd0, 4'h2, 4'h0, 4'h4, 1'b0);
    setv(11, 1'b0, 1'b0, 2'd2, 8'd0, 4'hD, 4'h2, 4'h4, 1'b0);
    setv(12, 1'b0, 1'b1, 2'd2, 8'd1, 4'h0, 4'h9, 4'h0, 1'b1);
    setv(13, 1'b0, 1'b1, 2'd0, 8'd6, 4'h6, 4'h9, 4'h0, 1'b1);
    setv(14, 1'b1, 1'b0, 2'd0, 8'd0, 4'h4, 4'h2, 4'h1, 1'b0);
    setv(15, 1'b0, 1'b0, 2'd0, 8'd0, 4'h4, 4'hB, 4'h0, 1'b1);
    setv(16, 1'b0, 1'b0, 2'd0, 8'd0, 4'h4, 4'h9, 4'h0, 1'b1);
    setv(17, 1'b0, 1'b0, 2'd0, 8'd0, 4'h6, 4'h1, 4'h0, 1'b1);
    setv(18, 1'b0, 1'b0, 2'd0, 8'd0, 4'hC, 4'h2, 4'h0, 1'b1);
    setv(19, 1'b0, 1'b0, 2'd0, 8'd0, 4'h4, 4'h8, 4'h0, 1'b1);
    setv(20, 1'b0, 1'b0, 2'd0, 8'd0, 4'h7, 4'h8, 4'h0, 1'b1);
    setv(21, 1'b0, 1'b1, 2'd3, 8'd5, 4'h4, 4'h3, 4'h0, 1'b1);
    setv(22, 1'b0, 1'b0, 2'd3, 8'd0, 4'hC, 4'h1, 4'h8, 1'b0);

    rst_n     = 1'b0;
    sync_i    = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_div   = 8'd0;
    valid5    = 1'b0;
    ch5       = 3'd0;

    #22;
    chk_reset_vals("por");
    #1;
    rst_n = 1'b1;

    // Main timeline: release mid-cycle, so this region is cycle 0.
    for (int k = 0; k < 23; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      sync_i    = vt[k].sync;
      cfg_valid = vt[k].valid;
      cfg_ch    = vt[k].ch;
      cfg_div   = vt[k].div;
      valid5    = (k == 5);
      ch5       = (k == 5) ? 3'd5 : 3'd0;
      #1;
      chk($sformatf("c%0d tick", k), {4'b0, tick}, {4'b0, vt[k].tick});
      chk($sformatf("c%0d dclk", k), {4'b0, dclk}, {4'b0, vt[k].dclk});
      chk($sformatf("c%0d pend", k), {4'b0, pend}, {4'b0, vt[k].pend});
      chk($sformatf("c%0d ready", k), {7'b0, cfg_ready}, {7'b0, vt[k].ready});
      chk5($sformatf("c%0d", k), (k < 15) ? (k % 4) : ((k - 15) % 4));
    end

    // Asynchronous reset mid-cycle while ch3 holds a pending divisor.
    sync_i    = 1'b0;
    cfg_valid = 1'b0;
    valid5    = 1'b0;
    rst_n     = 1'b0;
    #2;
    chk_reset_vals("async_rst");
    @(posedge clk);
    #1;
    chk_reset_vals("rst_hold");
    #2;
    rst_n = 1'b1;

    // After release every channel, ch3 included, runs the default period 4.
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      #1;
      chk($sformatf("r%0d tick", k), {4'b0, tick}, ((k % 4) == 3) ? 8'h0F : 8'h00);
      chk($sformatf("r%0d dclk", k), {4'b0, dclk}, ((k % 4) < 2) ? 8'h0F : 8'h00);
      chk($sformatf("r%0d pend", k), {4'b0, pend}, 8'h00);
      chk5($sformatf("r%0d", k), k % 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
